// File: rtl/lf_pkg.sv
// Shared constants and stage-1 bundle for the LF edge slicer path.
// State encoding is shared with other LF demodulator blocks.
package lf_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    localparam int HYST_SHIFT_DEF = 2;
    localparam int CNT_W_DEF      = 16;
    localparam int GLITCH_LEN_DEF = 3;

    typedef struct packed {
        logic [7:0] sample;
        logic [7:0] hi_th;
        logic [7:0] lo_th;
        logic       amp_ok;
    } lf_th_t;

endpackage

// File: rtl/lf_threshold_calc.sv
// Stage 1: registered sample plus hysteretic thresholds derived
// from the tracked min/max envelope.
module lf_threshold_calc
    import lf_pkg::*;
#(
    parameter int HYST_SHIFT = HYST_SHIFT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_adc_d,
    input  logic [7:0] i_min,
    input  logic [7:0] i_max,
    input  logic [7:0] i_amp_threshold,
    output lf_th_t     o_th
);

    logic [8:0] w_mid;
    logic [8:0] w_span;
    logic [8:0] w_hyst;
    logic [8:0] w_hi;
    logic [7:0] w_lo;
    lf_th_t     w_nxt;
    lf_th_t     r_th;

    assign w_mid  = ({1'b0, i_min} + {1'b0, i_max}) >> 1;
    assign w_span = (i_max >= i_min) ? ({1'b0, i_max} - {1'b0, i_min})
                                     : 9'd0;
    assign w_hyst = w_span >> HYST_SHIFT;
    assign w_hi   = w_mid + w_hyst;
    // Both thresholds clamp to the 8-bit sample range.
    assign w_lo   = (w_mid >= w_hyst) ? 8'(w_mid - w_hyst) : 8'd0;

    always_comb begin
        w_nxt        = '0;
        w_nxt.sample = i_adc_d;
        w_nxt.hi_th  = w_hi[8] ? 8'hFF : w_hi[7:0];
        w_nxt.lo_th  = w_lo;
        w_nxt.amp_ok = (w_span >= {1'b0, i_amp_threshold});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_th <= '0;
        end else begin
            r_th <= w_nxt;
        end
    end

    assign o_th = r_th;

endmodule

// File: rtl/lf_edge_slicer.sv
// Hysteretic level slicer with edge strobes and level-duration measurement.
// Optional glitch filter: define LF_EDGE_SLICER_GLITCH_FILTER_EN.
module lf_edge_slicer
    import lf_pkg::*;
#(
    parameter int HYST_SHIFT = HYST_SHIFT_DEF,
`ifdef LF_EDGE_SLICER_GLITCH_FILTER_EN
    parameter int GLITCH_LEN = GLITCH_LEN_DEF,
`endif
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       adc_d,
    input  logic [7:0]       min,
    input  logic [7:0]       max,
    input  logic [7:0]       amp_threshold,
    output logic             level,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic [CNT_W-1:0] pulse_len,
    output logic             pulse_valid,
    output logic             amp_ok
);

    lf_th_t           w_th;
    logic             w_hi;
    logic             w_lo;
    logic             w_req;
    logic             w_commit;
    logic             w_drop;
    logic             w_rise;
    logic             w_fall;
    logic             w_pv;
    logic [1:0]       w_nxt;
    logic [CNT_W-1:0] w_cnt_inc;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_plen;
    logic             r_rise;
    logic             r_fall;
    logic             r_pv;
    logic             r_amp;

    lf_threshold_calc #(
        .HYST_SHIFT(HYST_SHIFT)
    ) u_th (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_adc_d        (adc_d),
        .i_min          (min),
        .i_max          (max),
        .i_amp_threshold(amp_threshold),
        .o_th           (w_th)
    );

    assign w_hi      = (w_th.sample >= w_th.hi_th);
    assign w_lo      = (w_th.sample <= w_th.lo_th);
    assign w_drop    = !w_th.amp_ok && (r_state != ST_IDLE);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_req  = 1'b0;
        w_nxt  = r_state;
        w_rise = 1'b0;
        w_fall = 1'b0;
        w_pv   = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_hi) begin
                    w_req  = 1'b1;
                    w_nxt  = ST_HIGH;
                    w_rise = 1'b1;
                    w_pv   = 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_lo) begin
                    w_req  = 1'b1;
                    w_nxt  = ST_LOW;
                    w_fall = 1'b1;
                    w_pv   = 1'b1;
                end
            end
            default: begin
                if (w_hi) begin
                    w_req  = 1'b1;
                    w_nxt  = ST_HIGH;
                    w_rise = 1'b1;
                end else if (w_lo) begin
                    w_req  = 1'b1;
                    w_nxt  = ST_LOW;
                end
            end
        endcase
        // Low amplitude overrides any crossing.
        if (!w_th.amp_ok) begin
            w_req = 1'b0;
        end
    end

`ifdef LF_EDGE_SLICER_GLITCH_FILTER_EN
    localparam logic [3:0] GL_LAST = 4'(GLITCH_LEN - 1);

    logic [3:0] r_run;

    assign w_commit = w_req && (r_run == GL_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run <= '0;
        end else if (!w_req || w_commit) begin
            r_run <= '0;
        end else begin
            r_run <= r_run + 1'b1;
        end
    end
`else
    assign w_commit = w_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_plen  <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_pv    <= 1'b0;
            r_amp   <= 1'b0;
        end else begin
            r_amp  <= w_th.amp_ok;
            r_rise <= w_commit && w_rise;
            r_fall <= w_commit && w_fall;
            r_pv   <= w_commit && w_pv;
            if (w_drop) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else if (w_commit) begin
                r_state <= w_nxt;
                r_cnt   <= '0;
                if (w_pv) begin
                    r_plen <= w_cnt_inc;
                end
            end else if (r_state != ST_IDLE) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign level       = (r_state == ST_HIGH);
    assign edge_rise   = r_rise;
    assign edge_fall   = r_fall;
    assign pulse_len   = r_plen;
    assign pulse_valid = r_pv;
    assign amp_ok      = r_amp;

endmodule
